grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
//  Owns the single GRF write port (WE3/A3/WD3/PC) and shares it between two writers.
//  - Pipeline W stage: always wins, never stalls.
//  - Long-latency mult/div (MDU) result path: queued in a small FIFO and drained into idle write slots.
//  - Gives decode a pending-write query so it can stall on registers the FIFO has not yet written.
// PARAMETERS
//  DEPTH  2   MDU FIFO entries; power of two, >=2
//  AW     5   register address width
//  DW     32  data / PC width
// PORTS
//  clk      in   1   clock, rising edge
//  reset    in   1   asynchronous, active-low reset
//  p_we     in   1   pipeline W-stage write request
//  p_addr   in   AW  pipeline destination register
//  p_data   in   DW  pipeline write data
//  p_pc     in   DW  PC of the pipeline instruction
//  m_valid  in   1   MDU result valid
//  m_ready  out  1   FIFO can accept an MDU result
//  m_addr   in   AW  MDU destination register
//  m_data   in   DW  MDU result data
//  m_pc     in   DW  PC of the MDU instruction
//  q_addr1  in   AW  decode rs query
//  q_addr2  in   AW  decode rt query
//  q_hit    out  2   bit0/bit1: a live FIFO entry targets q_addr1/q_addr2
//  grf_we   out  1   to GRF WE3
//  grf_a3   out  AW  to GRF A3
//  grf_wd   out  DW  to GRF WD3
//  grf_pc   out  DW  to GRF PC
// BEHAVIOUR
//  Reset (reset==0, async)
//   - grf_we, grf_a3, grf_wd, grf_pc = 0.
//   - FIFO emptied; all entries invalid; count=0; q_hit=0; m_ready=0 while asserted.
//   - Asserting reset mid-drain discards all queued entries; no partial write is issued.
//  Output register
//   - grf_* are registered; 1-cycle latency from the selecting edge.
//   - The slot is re-evaluated every cycle; grf_we=0 when nothing is selected.
//  Slot selection at each edge
//   - Pipeline request live (p_we && p_addr!=0): it takes the slot.
//   - Otherwise: the FIFO head takes the slot if count>0.
//   - p_we with p_addr==0 is ignored; the slot is free for the FIFO.
//  FIFO
//   - m_ready = (count!=DEPTH), from registered count only; never depends on m_valid.
//   - Enqueue on m_valid && m_ready. m_addr==0: accepted, not stored.
//   - Full plus a same-cycle dequeue still refuses the enqueue (m_ready=0).
//   - Enqueue and dequeue in the same cycle: count unchanged; pointers wrap modulo DEPTH.
//   - Minimum MDU latency: accepted at edge k -> grf_we high in cycle k+2 (no empty-FIFO bypass).
//  WAW
//   - Pipeline write to X marks every live FIFO entry with addr X invalid (younger instruction wins).
//   - Invalid entries still dequeue in FIFO order but produce grf_we=0 for that slot.
//  q_hit
//   - Combinational over valid FIFO entries; the address compare is forced 0 for address 0.
//   - Excludes the grf_* register, because the GRF forwards WD3 itself.
// CONFIGURATION
//  GRF_WB_TRACE_EN
//   - Defined: every cycle with grf_we=1 prints
//     $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd).
//   - Defined: each refused cycle (m_valid && !m_ready) increments a 32-bit stall_cnt, reported at $finish.
//   - Undefined: no display, no counter; port list identical.
// TESTING
//  1. Pipeline only: p_we=1,p_addr=5,p_data=32'h1234 at edge 1 -> grf_we=1,a3=5,wd=1234 in cycle 2 only.
//  2. MDU idle path: m_valid=1,m_addr=8,m_data=32'hAA at edge 1, p_we=0 -> grf_we=1,a3=8 in cycle 3; m_ready stays 1.
//  3. Contention: 2 MDU results queued; p_we=1 for 3 cycles -> FIFO holds, m_ready=0.
//     Then p_we=0 -> heads written on the next 2 slots, in order.
//  4. WAW: queue MDU addr 9, then p_we to addr 9 -> pipeline write issued; queued entry drains with grf_we=0.
//     q_hit for q_addr1=9 drops after the kill edge.
//  5. Reset mid-drain: FIFO full, drop reset asynchronously mid-cycle -> grf_we=0 immediately, count=0.
//     After release, m_ready=1 and no stale write appears.
//  6. $0 writes: p_addr=0 with a queued MDU entry -> MDU entry takes that slot. m_addr=0 -> nothing ever written.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// Purpose: owns the GRF write port and shares it between the W stage (priority) and a queued MDU result path.
// Latency: grf_* registered, 1 cycle from the selecting edge; MDU results reach the GRF no earlier than 2 cycles after acceptance.
// Backpressure: m_ready low only when the FIFO is full (or in reset); the W stage is never stalled.
// Optional build macro GRF_WB_TRACE_EN adds a write trace and a refused-cycle counter; ports are unchanged.
module grf_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_data,
    input  logic [DW-1:0] p_pc,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_data,
    input  logic [DW-1:0] m_pc,
    input  logic [AW-1:0] q_addr1,
    input  logic [AW-1:0] q_addr2,
    output logic [1:0]    q_hit,
    output logic          grf_we,
    output logic [AW-1:0] grf_a3,
    output logic [DW-1:0] grf_wd,
    output logic [DW-1:0] grf_pc
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CONE = 1;
    localparam logic [PW-1:0] PONE = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t            mem [DEPTH];
    logic [DEPTH-1:0] vld, vld_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count, count_nxt;
    logic            p_live, deq, enq;

    // Slot arbitration, FIFO handshake and next-state of the entry bookkeeping.
    always_comb begin
        p_live  = p_we && (p_addr != '0);
        deq     = !p_live && (count != '0);
        m_ready = reset && (count != FULL);
        // $0 results are acknowledged but never occupy an entry.
        enq     = m_valid && m_ready && (m_addr != '0);
        vld_nxt = vld;
        // A W-stage write makes any queued older result to the same register obsolete.
        if (p_live) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem[i].addr == p_addr) vld_nxt[i] = 1'b0;
            end
        end
        if (deq) vld_nxt[rd_ptr] = 1'b0;
        // Applied after the kill: a result arriving this edge is not yet live.
        if (enq) vld_nxt[wr_ptr] = 1'b1;
        count_nxt = count;
        if (enq && !deq)      count_nxt = count + CONE;
        else if (!enq && deq) count_nxt = count - CONE;
    end

    // Decode hazard query over live entries; $0 never hits.
    always_comb begin
        q_hit = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (q_addr1 != '0) && (mem[i].addr == q_addr1)) q_hit[0] = 1'b1;
            if (vld[i] && (q_addr2 != '0) && (mem[i].addr == q_addr2)) q_hit[1] = 1'b1;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{addr: m_addr, data: m_data, pc: m_pc};
                wr_ptr      <= wr_ptr + PONE;
            end
            if (deq) rd_ptr <= rd_ptr + PONE;
            vld   <= vld_nxt;
            count <= count_nxt;
        end
    end

    // Registered GRF write port; a killed head still consumes its slot with the enable low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
        end else if (p_live) begin
            grf_we <= 1'b1;
            grf_a3 <= p_addr;
            grf_wd <= p_data;
            grf_pc <= p_pc;
        end else if (deq) begin
            grf_we <= vld[rd_ptr];
            grf_a3 <= mem[rd_ptr].addr;
            grf_wd <= mem[rd_ptr].data;
            grf_pc <= mem[rd_ptr].pc;
        end else begin
            grf_we <= 1'b0;
        end
    end

`ifdef GRF_WB_TRACE_EN
    logic [31:0] stall_cnt;

    // Counts cycles where an MDU result was offered but refused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt <= '0;
        else if (m_valid && !m_ready) stall_cnt <= stall_cnt + 32'd1;
    end

    // Trace every committed register write.
    always_ff @(posedge clk) begin
        if (grf_we) $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
    end

    final $display("grf_wb_arbiter stall_cnt=%0d", stall_cnt);
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a queue-based reference model.
module tb_grf_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_we, m_valid, m_ready, grf_we;
    logic [4:0]  p_addr, m_addr, q_addr1, q_addr2, grf_a3;
    logic [31:0] p_data, p_pc, m_data, m_pc, grf_wd, grf_pc;
    logic [1:0]  q_hit;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
        bit          v;
    } rent_t;

    rent_t       q[$];
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_pc;

    grf_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit(q_hit),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_hit(input logic [4:0] a1, input logic [4:0] a2);
        logic [1:0] h = 2'b00;
        foreach (q[i]) begin
            if (q[i].v && a1 != 0 && q[i].a == a1) h[0] = 1'b1;
            if (q[i].v && a2 != 0 && q[i].a == a2) h[1] = 1'b1;
        end
        return h;
    endfunction

    // One cycle: called at a negedge; drives inputs, checks combinational outputs,
    // advances the model across the next edge and checks the registered write port.
    task automatic step(input string tag,
                        input logic pwe, input logic [4:0] pa, input logic [31:0] pd, input logic [31:0] ppc,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [31:0] mpc,
                        input logic [4:0] qa1, input logic [4:0] qa2);
        logic  mr;
        rent_t e;
        p_we = pwe; p_addr = pa; p_data = pd; p_pc = ppc;
        m_valid = mv; m_addr = ma; m_data = md; m_pc = mpc;
        q_addr1 = qa1; q_addr2 = qa2;
        #1;
        mr = (q.size() != DEPTH);
        chk({tag, ".m_ready"}, {63'd0, m_ready}, {63'd0, mr});
        chk({tag, ".q_hit"}, {62'd0, q_hit}, {62'd0, model_hit(qa1, qa2)});
        if (pwe && pa != 0) begin
            e_we = 1'b1; e_a3 = pa; e_wd = pd; e_pc = ppc;
            foreach (q[i]) if (q[i].a == pa) q[i].v = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            e_we = e.v; e_a3 = e.a; e_wd = e.d; e_pc = e.pc;
        end else begin
            e_we = 1'b0;
        end
        if (mv && mr && ma != 0) q.push_back('{a: ma, d: md, pc: mpc, v: 1'b1});
        @(negedge clk);
        chk({tag, ".grf_we"}, {63'd0, grf_we}, {63'd0, e_we});
        if (e_we) begin
            chk({tag, ".grf_a3"}, {59'd0, grf_a3}, {59'd0, e_a3});
            chk({tag, ".grf_wd"}, {32'd0, grf_wd}, {32'd0, e_wd});
            chk({tag, ".grf_pc"}, {32'd0, grf_pc}, {32'd0, e_pc});
        end
    endtask

    task automatic idle(input string tag, input logic [4:0] qa1);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, qa1, 0);
    endtask

    initial begin
        reset = 1'b0;
        p_we = 0; p_addr = 0; p_data = 0; p_pc = 0;
        m_valid = 1; m_addr = 3; m_data = 0; m_pc = 0;
        q_addr1 = 3; q_addr2 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.grf_we", {63'd0, grf_we}, 64'd0);
        chk("rst.grf_a3", {59'd0, grf_a3}, 64'd0);
        chk("rst.grf_wd", {32'd0, grf_wd}, 64'd0);
        chk("rst.grf_pc", {32'd0, grf_pc}, 64'd0);
        chk("rst.m_ready", {63'd0, m_ready}, 64'd0);
        chk("rst.q_hit", {62'd0, q_hit}, 64'd0);
        m_valid = 0;
        reset = 1'b1;

        // Pipeline only: one write, then the slot goes idle.
        step("t1a", 1, 5, 32'h1234, 32'h100, 0, 0, 0, 0, 0, 0);
        idle("t1b", 0);
        chk("t1.we_direct", {63'd0, grf_we}, 64'd0);

        // MDU through an idle FIFO: written two edges after acceptance.
        step("t2a", 0, 0, 0, 0, 1, 8, 32'hAA, 32'h200, 8, 0);
        step("t2b", 0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
        chk("t2.a3_direct", {59'd0, grf_a3}, 64'd8);
        idle("t2c", 8);

        // Contention: the pipeline holds the slot while the FIFO fills and refuses.
        step("t3a", 1, 2, 32'h2, 32'h300, 1, 10, 32'hA0, 32'h310, 10, 11);
        step("t3b", 1, 3, 32'h3, 32'h304, 1, 11, 32'hB0, 32'h314, 10, 11);
        step("t3c", 1, 4, 32'h4, 32'h308, 1, 12, 32'hC0, 32'h318, 12, 11);
        chk("t3.m_ready_full", {63'd0, m_ready}, 64'd0);
        idle("t3d", 10);
        idle("t3e", 11);
        idle("t3f", 0);

        // WAW: the pipeline write to $9 kills the queued result for $9.
        step("t4a", 0, 0, 0, 0, 1, 9, 32'h99, 32'h400, 9, 0);
        step("t4b", 1, 9, 32'h77, 32'h404, 0, 0, 0, 0, 9, 9);
        idle("t4c", 9);
        chk("t4.q_hit_dropped", {62'd0, q_hit}, 64'd0);
        idle("t4d", 0);

        // $0 handling: a $0 pipeline write leaves the slot to the FIFO; an $0 result is never written.
        step("t6a", 0, 0, 0, 0, 1, 7, 32'h7, 32'h500, 7, 0);
        step("t6b", 1, 0, 32'hDEAD, 32'h504, 0, 0, 0, 0, 7, 0);
        step("t6c", 0, 0, 0, 0, 1, 0, 32'hBEEF, 32'h508, 0, 0);
        idle("t6d", 0);
        idle("t6e", 0);

        // Reset in the middle of a drain.
        step("t5a", 1, 1, 32'h1, 32'h600, 1, 13, 32'hD0, 32'h610, 0, 0);
        step("t5b", 1, 1, 32'h1, 32'h604, 1, 14, 32'hE0, 32'h614, 0, 0);
        p_we = 0; m_valid = 0; q_addr1 = 14; q_addr2 = 0;
        @(posedge clk);
        #1;
        chk("t5.drain_we", {63'd0, grf_we}, 64'd1);
        chk("t5.drain_a3", {59'd0, grf_a3}, 64'd13);
        #2;
        reset = 1'b0;
        #1;
        chk("t5.rst_we", {63'd0, grf_we}, 64'd0);
        chk("t5.rst_a3", {59'd0, grf_a3}, 64'd0);
        chk("t5.rst_ready", {63'd0, m_ready}, 64'd0);
        chk("t5.rst_hit", {62'd0, q_hit}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        idle("t5c", 14);
        idle("t5d", 14);

        // Random traffic over a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 6)), $urandom, $urandom,
                 ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 6)), $urandom, $urandom,
                 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
